// File: rtl/hdmi_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hdmi_decode
//  Purpose  : TMDS receive decoder. Aligns each of the three 10-bit channels
//             to its word boundary by hunting for control-token runs, then
//             decodes data words back to 24-bit RGB and recovers the data
//             enable plus the blue-channel sync bits.
//  Ports    : clk      - pixel clock
//             reset    - asynchronous, active-high reset
//             data_in  - raw words {red[29:20], green[19:10], blue[9:0]},
//                        bit 0 of each word earliest on the wire
//             locked   - all three channels aligned and locked
//             active   - data period (registered pixel valid)
//             h_sync   - blue control bit c0 (held outside control periods)
//             v_sync   - blue control bit c1 (held outside control periods)
//             rgb      - {red, green, blue} decoded pixel
//  Config   : HDMI_DECODE_BLANK_RGB_EN - when defined, rgb is forced to zero
//             on every non-active cycle; otherwise it holds the last pixel.
//  Revision : 1.0 - initial release
// ============================================================================
module hdmi_decode #(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] data_in,
    output logic        locked,
    output logic        active,
    output logic        h_sync,
    output logic        v_sync,
    output logic [23:0] rgb
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int TO_W  = $clog2(SEARCH_TIMEOUT);

    localparam logic [RUN_W-1:0] c_run_one  = RUN_W'(1);
    localparam logic [RUN_W-1:0] c_run_full = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] c_run_last = RUN_W'(LOCK_COUNT - 1);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [3:0]       c_off_max  = 4'd9;

    localparam logic [9:0] c_tok_00 = 10'h354;
    localparam logic [9:0] c_tok_01 = 10'h0AB;
    localparam logic [9:0] c_tok_10 = 10'h154;
    localparam logic [9:0] c_tok_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    function automatic logic is_token(input logic [9:0] q);
        return (q == c_tok_00) || (q == c_tok_01) ||
               (q == c_tok_10) || (q == c_tok_11);
    endfunction

    // Returns {c1, c0}; only meaningful when is_token(q) is true.
    function automatic logic [1:0] token_ctrl(input logic [9:0] q);
        logic [1:0] c;
        case (q)
            c_tok_01: c = 2'b01;
            c_tok_10: c = 2'b10;
            c_tok_11: c = 2'b11;
            default:  c = 2'b00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    logic [2:0][9:0] w_words;      // registered aligned word per channel
    logic [2:0]      w_word_tok;   // aligned word is a control token
    logic [2:0]      w_lock_next;  // channel will be LOCKED after this edge

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [9:0]       r_prev;
        logic [9:0]       r_word;
        logic [3:0]       r_off;
        logic [RUN_W-1:0] r_run;
        logic [TO_W-1:0]  r_timeout;
        logic             r_skip;
        state_t           r_state;

        logic [19:0] w_window;
        logic [9:0]  w_next;
        logic        w_tok;
        logic        w_run_done;
        logic        w_to_done;

        assign w_window = {data_in[ch*10 +: 10], r_prev};
        assign w_next   = w_window[r_off +: 10];

        // The first word loaded after an offset step straddles two
        // alignments, so it is never allowed to count as a token.
        assign w_tok      = is_token(w_next) && !r_skip;
        assign w_run_done = w_tok && (r_run >= c_run_last);
        assign w_to_done  = (r_timeout == c_to_last);

        assign w_lock_next[ch] = ((r_state == ST_CONFIRM) && w_run_done) ||
                                 ((r_state == ST_LOCKED) && (w_run_done || !w_to_done));
        assign w_words[ch]     = r_word;
        assign w_word_tok[ch]  = is_token(r_word);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_prev    <= '0;
                r_word    <= '0;
                r_off     <= '0;
                r_run     <= '0;
                r_timeout <= '0;
                r_skip    <= 1'b0;
                r_state   <= ST_SEARCH;
            end else begin
                r_prev <= data_in[ch*10 +: 10];
                r_word <= w_next;
                r_skip <= 1'b0;
                case (r_state)
                    ST_SEARCH: begin
                        if (w_tok) begin
                            // A token outranks a simultaneous timeout.
                            r_state <= ST_CONFIRM;
                            r_run   <= c_run_one;
                        end else if (w_to_done) begin
                            r_timeout <= '0;
                            r_off     <= (r_off == c_off_max) ? 4'd0 : r_off + 4'd1;
                            r_skip    <= 1'b1;
                        end else begin
                            r_timeout <= r_timeout + 1'b1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (w_run_done) begin
                            r_state   <= ST_LOCKED;
                            r_run     <= c_run_full;
                            r_timeout <= '0;
                        end else if (w_tok) begin
                            r_run <= r_run + 1'b1;
                        end else begin
                            r_state <= ST_SEARCH;
                            r_run   <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_run_done) begin
                            // A completed run outranks a simultaneous timeout.
                            r_run     <= c_run_full;
                            r_timeout <= '0;
                        end else begin
                            r_run <= w_tok ? r_run + 1'b1 : '0;
                            if (w_to_done) begin
                                r_state   <= ST_SEARCH;
                                r_timeout <= '0;
                                r_run     <= '0;
                            end else begin
                                r_timeout <= r_timeout + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                        r_run   <= '0;
                    end
                endcase
            end
        end
    end

    // locked/active follow the next FSM state so they move on the same edge
    // as the channel state itself.
    logic       w_all_locked;
    logic       w_pixel;
    logic [1:0] w_blue_ctrl;

    assign w_all_locked = &w_lock_next;
    assign w_pixel      = w_all_locked && !(|w_word_tok);
    assign w_blue_ctrl  = token_ctrl(w_words[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
            active <= 1'b0;
            h_sync <= 1'b0;
            v_sync <= 1'b0;
            rgb    <= '0;
        end else begin
            locked <= w_all_locked;
            active <= w_pixel;
            if (w_word_tok[0]) begin
                h_sync <= w_blue_ctrl[0];
                v_sync <= w_blue_ctrl[1];
            end
            if (w_pixel) begin
                rgb <= {tmds_decode(w_words[2]), tmds_decode(w_words[1]),
                        tmds_decode(w_words[0])};
            end
`ifdef HDMI_DECODE_BLANK_RGB_EN
            else begin
                rgb <= '0;
            end
`else
            // rgb holds the last active pixel through blanking.
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hdmi_decode
//  Purpose  : Directed self-checking bench for hdmi_decode. Covers reset,
//             aligned lock, data decode, sync recovery, blanking, short
//             token runs, lock loss on timeout, misaligned search and
//             asynchronous reset while locked.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_decode;

    localparam logic [9:0]  TOK_00 = 10'h354;
    localparam logic [9:0]  TOK_01 = 10'h0AB;
    localparam logic [9:0]  TOK_10 = 10'h154;
    localparam logic [9:0]  TOK_11 = 10'h2AB;
    localparam logic [29:0] PX_TOK = {TOK_00, TOK_00, TOK_00};
    // Hand-encoded pixels {red, green, blue} and their decoded RGB.
    localparam logic [29:0] PX_A  = {10'h10E, 10'h1EC, 10'h132};
    localparam logic [23:0] RGB_A = 24'h123456;
    localparam logic [29:0] PX_B  = {10'h2F0, 10'h200, 10'h300};
    localparam logic [23:0] RGB_B = 24'hEFFF01;
    localparam logic [29:0] PX_C  = {10'h100, 10'h100, 10'h100};
    localparam logic [23:0] RGB_C = 24'h000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] data_in = '0;
    logic        locked;
    logic        active;
    logic        h_sync;
    logic        v_sync;
    logic [23:0] rgb;

    int          n_cmp = 0;
    int          n_err = 0;
    int          shift = 0;
    logic [29:0] prev_words = '0;
    logic [23:0] exp_blank;

    hdmi_decode dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .locked  (locked),
        .active  (active),
        .h_sync  (h_sync),
        .v_sync  (v_sync),
        .rgb     (rgb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Presents one stream word per channel. With shift = 3 the serial stream
    // is delayed by 3 bits, so each raw word carries the tail of the
    // previous word in its low bits. Outputs for the word presented in one
    // call are visible after the call two later, in both modes.
    task automatic drive(input logic [29:0] w);
        if (shift == 0) begin
            data_in = w;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                data_in[ch*10 +: 10] = {w[ch*10 +: 7], prev_words[ch*10+7 +: 3]};
            end
        end
        prev_words = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        data_in    = '0;
        prev_words = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [29:0] stream_word(input int c);
        if ((c % 2000) < 40) return PX_TOK;
        case (c % 3)
            0:       return PX_A;
            1:       return PX_B;
            default: return PX_C;
        endcase
    endfunction

    function automatic logic [23:0] stream_rgb(input int c);
        case (c % 3)
            0:       return RGB_A;
            1:       return RGB_B;
            default: return RGB_C;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef HDMI_DECODE_BLANK_RGB_EN
        exp_blank = RGB_C;
`else
        exp_blank = RGB_A;
`endif
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_active", {31'd0, active}, 32'd0);
        check_eq("rst_hsync",  {31'd0, h_sync}, 32'd0);
        check_eq("rst_vsync",  {31'd0, v_sync}, 32'd0);
        check_eq("rst_rgb",    {8'd0, rgb}, 32'd0);
        reset = 1'b0;

        // ---------------- aligned lock ----------------
        for (int i = 0; i < 15; i++) drive(PX_TOK);
        drive(PX_TOK);                                   // 16th token sampled
        check_eq("lock_before_16th", {31'd0, locked}, 32'd0);
        drive(PX_C);                                     // 16th token registered
        check_eq("lock_on_16th", {31'd0, locked}, 32'd1);
        drive(PX_A);
        check_eq("act_tok_tail", {31'd0, active}, 32'd0);
        check_eq("hs_tok00", {31'd0, h_sync}, 32'd0);
        check_eq("vs_tok00", {31'd0, v_sync}, 32'd0);
        drive(PX_B);
        check_eq("act_first_px", {31'd0, active}, 32'd1);
        check_eq("rgb_first_px", {8'd0, rgb}, {8'd0, RGB_C});
        drive(PX_C);
        check_eq("rgb_px_a", {8'd0, rgb}, {8'd0, RGB_A});
        drive(PX_C);
        check_eq("rgb_px_b", {8'd0, rgb}, {8'd0, RGB_B});

        // ---------------- sync recovery + blank ----------------
        drive({TOK_00, TOK_00, TOK_01});
        drive({TOK_00, TOK_00, TOK_10});
        drive({TOK_00, TOK_00, TOK_11});
        check_eq("hs_tok01", {31'd0, h_sync}, 32'd1);
        check_eq("vs_tok01", {31'd0, v_sync}, 32'd0);
        check_eq("act_ctrl", {31'd0, active}, 32'd0);
        drive(PX_A);
        check_eq("hs_tok10", {31'd0, h_sync}, 32'd0);
        check_eq("vs_tok10", {31'd0, v_sync}, 32'd1);
        drive(PX_B);
        check_eq("hs_tok11", {31'd0, h_sync}, 32'd1);
        check_eq("vs_tok11", {31'd0, v_sync}, 32'd1);
        drive(PX_A);
        check_eq("act_after_sync", {31'd0, active}, 32'd1);
        check_eq("rgb_after_sync", {8'd0, rgb}, {8'd0, RGB_A});
        check_eq("hs_hold", {31'd0, h_sync}, 32'd1);
        check_eq("vs_hold", {31'd0, v_sync}, 32'd1);
        drive(PX_TOK);
        check_eq("rgb_px_b2", {8'd0, rgb}, {8'd0, RGB_B});
        drive(PX_TOK);
        check_eq("rgb_last_px", {8'd0, rgb}, {8'd0, RGB_A});
        check_eq("act_last_px", {31'd0, active}, 32'd1);
        drive(PX_TOK);
        check_eq("act_blank", {31'd0, active}, 32'd0);
        check_eq("rgb_blank", {8'd0, rgb}, {8'd0, exp_blank});
        check_eq("hs_back00", {31'd0, h_sync}, 32'd0);

        // ---------------- short run, then lock loss ----------------
        do_reset();
        for (int i = 0; i < 15; i++) drive(PX_TOK);
        drive(PX_C);
        drive(PX_TOK);                                   // breaker word evaluated
        check_eq("short_nolock", {31'd0, locked}, 32'd0);
        for (int i = 0; i < 15; i++) drive(PX_TOK);
        check_eq("short_15of16", {31'd0, locked}, 32'd0);
        drive(PX_A);
        check_eq("short_relock", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 4095; i++) drive(PX_A);
        check_eq("loss_4095_locked", {31'd0, locked}, 32'd1);
        check_eq("loss_4095_active", {31'd0, active}, 32'd1);
        drive(PX_A);
        check_eq("loss_4096_locked", {31'd0, locked}, 32'd0);
        check_eq("loss_4096_active", {31'd0, active}, 32'd0);

        // ---------------- misaligned search (stream delayed 3 bits) ----------------
        shift = 3;
        do_reset();
        for (int c = 0; c <= 14046; c++) begin
            drive(stream_word(c));
            if (c == 12100) check_eq("mis_nolock_off2", {31'd0, locked}, 32'd0);
            if (c == 14015) check_eq("mis_nolock_15", {31'd0, locked}, 32'd0);
            if (c == 14016) check_eq("mis_lock", {31'd0, locked}, 32'd1);
            if (c == 14041) check_eq("mis_act_tok", {31'd0, active}, 32'd0);
            if (c >= 14042 && c <= 14046) begin
                check_eq("mis_active", {31'd0, active}, 32'd1);
                check_eq("mis_rgb", {8'd0, rgb}, {8'd0, stream_rgb(c - 2)});
            end
        end

        // ---------------- asynchronous reset while locked ----------------
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_locked", {31'd0, locked}, 32'd0);
        check_eq("async_rst_active", {31'd0, active}, 32'd0);
        check_eq("async_rst_rgb", {8'd0, rgb}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        shift = 0;
        drive(PX_TOK);
        drive(PX_TOK);
        check_eq("post_rst_nolock", {31'd0, locked}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hdmi_decode.md
# hdmi_decode

Receive-side counterpart of the TMDS transmit path. Takes three 10-bit TMDS words per pixel clock from the upstream deserializers and aligns each channel to the 10-bit word boundary by searching for control-token runs. It then decodes the TMDS data words back to 24-bit RGB and recovers `active`, `h_sync` and `v_sync`. It sits between the per-channel deserializers and the video timing/capture logic, entirely in the pixel-clock domain.

## Interface
- `LOCK_COUNT`, 16: consecutive control tokens at the current offset required to declare a channel locked.
- `SEARCH_TIMEOUT`, 4096: cycles without a qualifying token run before the offset advances (SEARCH) or lock drops (LOCKED); must exceed one video line.
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  30  raw words. `[9:0]` blue/ch0, `[19:10]` green/ch1, `[29:20]` red/ch2. Bit 0 of each word is earliest on the wire.
- `locked`  out  1  all three channels in LOCKED.
- `active`  out  1  data period.
- `h_sync`  out  1  blue control bit c0.
- `v_sync`  out  1  blue control bit c1.
- `rgb`  out  24  `{red, green, blue}`, 8 bits each.

## Operation
- Per channel: `prev` register holds the previous `data_in` word. Window `w = {data_in, prev}` (20 bits). The aligned word register loads `w[off+9:off]`, with `off` in 0..9.
- Control tokens (aligned word, bit 9..0):
  - `0x354` = c1c0 00
  - `0x0AB` = 01
  - `0x154` = 10
  - `0x2AB` = 11
- Per-channel alignment FSM, states SEARCH, CONFIRM, LOCKED, with a run counter and a timeout counter:
  - SEARCH:
    - Token → CONFIRM with run = 1.
    - Otherwise timeout += 1. On reaching `SEARCH_TIMEOUT`, `off` = (`off` == 9) ? 0 : `off` + 1, and timeout clears.
  - CONFIRM:
    - Token → run += 1. When run reaches `LOCK_COUNT` → LOCKED and timeout clears.
    - Non-token → SEARCH, `off` unchanged, run cleared.
  - LOCKED:
    - Timeout counts every cycle and clears whenever a token run reaches `LOCK_COUNT`.
    - On reaching `SEARCH_TIMEOUT` → SEARCH, `off` unchanged.
  - Counters saturate and never wrap.
- `off` changes take effect on the next aligned-word load. The first word after a change is garbage and must not be treated as a token.
- Data decode (word q): `d = q[9] ? ~q[7:0] : q[7:0]`. `out[0] = d[0]`. For i = 1..7: `out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`.
- Output register:
  - `active` = 1 only when `locked` = 1 and all three aligned words are non-tokens.
  - When the blue word is a token, `h_sync`/`v_sync` load c0/c1. Otherwise they hold their last value.
  - `rgb` loads the decoded words when `active` loads 1.
- Channel deskew is not performed. Channels arriving in different words give `active` = 0 on the mismatched cycles.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - All FSMs in SEARCH.
  - `off` = 0, counters = 0, `prev` = 0, aligned words = 0.
  - `locked` = 0, `active` = 0, `h_sync` = 0, `v_sync` = 0, `rgb` = 0.
- Latency: with `off` = 0, a word sampled at edge k appears on outputs after edge k+2. With `off` > 0, the word that completes in the `data_in` sampled at edge k appears after edge k+1 (the same pipeline as k+2 for `off` = 0, one word earlier in the stream).
- `locked` rises on the same edge as the last channel enters LOCKED. It falls on the edge any channel leaves LOCKED, and `active` falls with it.
- Simultaneous events:
  - Timeout expiry and token in the same SEARCH cycle: the token wins → CONFIRM, `off` unchanged.
  - Run reaching `LOCK_COUNT` and timeout expiry in the same LOCKED cycle: the run wins, timeout clears.
- Reset mid-stream drops lock immediately. Re-lock needs a fresh token run of `LOCK_COUNT`.

## Configuration
- `HDMI_DECODE_BLANK_RGB_EN`:
  - Defined: `rgb` loads 0 on every cycle where `active` loads 0.
  - Undefined: `rgb` holds the last active pixel through blanking.

## Test plan
- **Aligned lock.** Stimulus: `off` = 0 stream, 16 tokens `0x354` on every channel, then data words. Required response: `locked` = 1 on the edge the 16th token is registered. The first data word `0x100`, which decodes to `0x00`, appears with `active` = 1 two edges after sampling.
- **Misaligned search.** Stimulus: bit stream shifted by 3 bits, long token runs every 2000 cycles. Required response: `off` steps 0→1→2→3 on timeouts, then lock is achieved at `off` = 3, and `rgb` matches the transmitted pixels.
- **Sync recovery.** Stimulus: blue tokens `0x0AB`, `0x154`, `0x2AB`. Required response: (`h_sync`, `v_sync`) = (1,0), (0,1), (1,1), and both hold their values through the following data words.
- **Short run.** Stimulus: 15 tokens, then one data word, then 16 tokens. Required response: the FSM returns to SEARCH after the 15th token with `off` unchanged, and locks only after the later 16-token run.
- **Lock loss.** Stimulus: in LOCKED, feed 4096 data words with no token run. Required response: `locked` and `active` fall on the 4096th cycle.
- **Blank.** Stimulus: `active` falls after pixel `0x123456`. Required response: `rgb` = 0 when `HDMI_DECODE_BLANK_RGB_EN` is defined, and holds `0x123456` when it is undefined.
